// File: rtl/pc_fetch.sv
// pc_fetch: MIPS program-counter stage feeding Add1, selecting next PC from sequential/branch/jump/trap sources
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   stall                   hold pc and re-fetch the same address
//   branch_taken, branch_offset   conditional branch request and sign-extended word offset
//   jump, jump_target       J-type jump request and 26-bit target field
//   add_rst, add_overflow   Add1 result (pc + 4) and its overflow flag
//   pc, inc                 current PC and constant 4, to Add1.r1 / Add1.r2
//   fetch_valid             pc is a valid fetch address this cycle
//   exc, epc                one-cycle trap pulse and PC of the trapping instruction
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_PC   = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic [31:0] add_rst,
   input  logic        add_overflow,
   output logic [31:0] pc,
   output logic [31:0] inc,
   output logic        fetch_valid,
   output logic        exc,
   output logic [31:0] epc
);
   typedef enum logic [1:0] {BOOT, RUN, STALL, TRAP} state_t;
   state_t state, state_nx;
   logic [31:0] pc_nx, epc_nx, br_pc, jmp_pc;
   logic fv_nx, exc_nx;
   assign inc    = 32'd4;
   assign br_pc  = add_rst + {branch_offset[29:0], 2'b00};
   assign jmp_pc = {add_rst[31:28], jump_target, 2'b00};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         fetch_valid <= 1'b0;
         exc         <= 1'b0;
         epc         <= 32'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         fetch_valid <= fv_nx;
         exc         <= exc_nx;
         epc         <= epc_nx;
      end
   // Control inputs only matter in RUN; STALL and TRAP hold pc and ignore them.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      epc_nx   = epc;
      fv_nx    = fetch_valid;
      exc_nx   = 1'b0;
      case (state)
         BOOT: begin
            state_nx = RUN;
            fv_nx    = 1'b1;
         end
         RUN:
            if (stall) begin
               state_nx = STALL;
               fv_nx    = 1'b0;
            end else if (add_overflow) begin
               state_nx = TRAP;
               epc_nx   = pc;
               pc_nx    = EXC_PC;
               exc_nx   = 1'b1;
               fv_nx    = 1'b0;
            end else
               pc_nx = jump ? jmp_pc : branch_taken ? br_pc : add_rst;
         STALL:
            if (!stall) begin
               state_nx = RUN;
               fv_nx    = 1'b1;
            end
         TRAP: begin
            state_nx = stall ? STALL : RUN;
            fv_nx    = !stall;
         end
         default: state_nx = BOOT;
      endcase
   end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed checks of pc_fetch with a behavioural Add1 attached
module tb_pc_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, force_ovf = 1'b0;
   logic [31:0] branch_offset = 32'd0;
   logic [25:0] jump_target = 26'd0;
   logic [31:0] pc_a, inc_a, epc_a, sum_a, pc_b, inc_b, epc_b, sum_b;
   logic        fv_a, exc_a, ovf_a, fv_b, exc_b, ovf_b;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   // Add1: pc + 4, signed overflow when a non-negative pc wraps negative
   assign sum_a = pc_a + inc_a;
   assign ovf_a = (~pc_a[31] & sum_a[31]) | force_ovf;
   assign sum_b = pc_b + inc_b;
   assign ovf_b = ~pc_b[31] & sum_b[31];

   pc_fetch dut_a (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .add_rst(sum_a), .add_overflow(ovf_a), .pc(pc_a), .inc(inc_a),
      .fetch_valid(fv_a), .exc(exc_a), .epc(epc_a));

   pc_fetch #(.RESET_PC(32'h7FFF_FFF8)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .add_rst(sum_b), .add_overflow(ovf_b), .pc(pc_b), .inc(inc_b),
      .fetch_valid(fv_b), .exc(exc_b), .epc(epc_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // pc, fetch_valid, exc of instance A in one call
   task automatic chk_a(input string tag, input logic [31:0] p, input logic f, input logic e);
      chk({tag, ".pc"}, pc_a, p);
      chk({tag, ".fv"}, {31'd0, fv_a}, {31'd0, f});
      chk({tag, ".exc"}, {31'd0, exc_a}, {31'd0, e});
   endtask

   initial begin
      #1;
      chk_a("rst", 32'h0, 1'b0, 1'b0);
      chk("rst.epc", epc_a, 32'h0);
      chk("rst.inc", inc_a, 32'd4);
      step;
      rst_n = 1'b1;
      chk_a("boot", 32'h0, 1'b0, 1'b0);
      step; chk_a("run0", 32'h0, 1'b1, 1'b0);
      step; chk_a("run4", 32'h4, 1'b1, 1'b0);
      step; chk_a("run8", 32'h8, 1'b1, 1'b0);
      step; chk_a("runC", 32'hC, 1'b1, 1'b0);
      step; chk_a("run10", 32'h10, 1'b1, 1'b0);
      branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
      step; chk_a("branch_back", 32'hC, 1'b1, 1'b0);
      jump = 1'b1; jump_target = 26'h40;
      step; chk_a("jump_wins", 32'h100, 1'b1, 1'b0);
      branch_taken = 1'b0; jump_target = 26'h2;
      step; chk_a("jump_to8", 32'h8, 1'b1, 1'b0);
      jump = 1'b0; jump_target = 26'h40; stall = 1'b1;
      step; chk_a("stall1", 32'h8, 1'b0, 1'b0);
      jump = 1'b1;
      step; chk_a("stall2", 32'h8, 1'b0, 1'b0);
      jump = 1'b0;
      step; chk_a("stall3", 32'h8, 1'b0, 1'b0);
      stall = 1'b0;
      step; chk_a("resume", 32'h8, 1'b1, 1'b0);
      step; chk_a("jump_ignored", 32'hC, 1'b1, 1'b0);
      stall = 1'b1; force_ovf = 1'b1;
      step; chk_a("ovf_stall1", 32'hC, 1'b0, 1'b0);
      step; chk_a("ovf_stall2", 32'hC, 1'b0, 1'b0);
      stall = 1'b0;
      step; chk_a("ovf_resume", 32'hC, 1'b1, 1'b0);
      step; chk_a("ovf_trap", 32'h80, 1'b0, 1'b1);
      chk("ovf_trap.epc", epc_a, 32'hC);
      force_ovf = 1'b0;
      step; chk_a("vec_valid", 32'h80, 1'b1, 1'b0);
      step; chk_a("vec_next", 32'h84, 1'b1, 1'b0);
      chk("epc_hold", epc_a, 32'hC);
      step; chk_a("vec_88", 32'h88, 1'b1, 1'b0);
      force_ovf = 1'b1;
      step; chk_a("trap2", 32'h80, 1'b0, 1'b1);
      chk("trap2.epc", epc_a, 32'h88);
      force_ovf = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk_a("async_rst", 32'h0, 1'b0, 1'b0);
      chk("async_rst.epc", epc_a, 32'h0);
      #2 rst_n = 1'b1;
      step; chk_a("reboot", 32'h0, 1'b1, 1'b0);
      step; chk_a("reboot4", 32'h4, 1'b1, 1'b0);
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      chk("b.boot.pc", pc_b, 32'h7FFF_FFF8);
      chk("b.boot.fv", {31'd0, fv_b}, 32'd0);
      step;
      chk("b.run.pc", pc_b, 32'h7FFF_FFF8);
      chk("b.run.fv", {31'd0, fv_b}, 32'd1);
      step;
      chk("b.next.pc", pc_b, 32'h7FFF_FFFC);
      step;
      chk("b.trap.exc", {31'd0, exc_b}, 32'd1);
      chk("b.trap.epc", epc_b, 32'h7FFF_FFFC);
      chk("b.trap.pc", pc_b, 32'h80);
      chk("b.trap.fv", {31'd0, fv_b}, 32'd0);
      step;
      chk("b.vec.exc", {31'd0, exc_b}, 32'd0);
      chk("b.vec.fv", {31'd0, fv_b}, 32'd1);
      chk("b.vec.pc", pc_b, 32'h80);
      step;
      chk("b.vec84.pc", pc_b, 32'h84);
      chk("b.epc_hold", epc_b, 32'h7FFF_FFFC);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter stage of the MIPS datapath, directly upstream of `Add1`. Holds the architectural PC and drives it into `Add1` as `r1`, with the constant 4 as `r2`. Takes the incremented value and overflow flag back to select the next PC from sequential, branch, jump or exception sources. Issues a fetch-valid qualifier to instruction memory and handles stalls and overflow traps.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `EXC_PC`, 32'h0000_0080, exception vector loaded on trap.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `stall`  in  1  hold PC; re-fetch same address.
- `branch_taken`  in  1  take conditional branch this cycle.
- `branch_offset`  in  32  sign-extended word offset (imm16 already extended).
- `jump`  in  1  take J-type jump this cycle.
- `jump_target`  in  26  J-type target field.
- `add_rst`  in  32  `Add1.rst` (= pc + 4).
- `add_overflow`  in  1  `Add1.overflow`.
- `pc`  out  32  current PC, to `Add1.r1` and instruction memory.
- `inc`  out  32  constant 32'd4, to `Add1.r2`.
- `fetch_valid`  out  1  `pc` is a valid fetch address this cycle.
- `exc`  out  1  one-cycle trap pulse.
- `epc`  out  32  PC of the instruction that trapped.

## Operation
- FSM states: BOOT, RUN, STALL, TRAP. All outputs except `inc` are registered.
- Reset (`rst_n`=0, asynchronous): state=BOOT, `pc`=RESET_PC, `fetch_valid`=0, `exc`=0, `epc`=0.
- Branch target = `add_rst` + (`branch_offset` << 2), 32-bit modulo wrap, no trap.
- Jump target = {`add_rst`[31:28], `jump_target`, 2'b00}.
- BOOT -> RUN unconditionally. `pc` held; `fetch_valid`<=1.
- RUN, priority stall > add_overflow > jump > branch_taken > sequential:
  - stall: -> STALL. `pc` held; `fetch_valid`<=0.
  - add_overflow: -> TRAP. `epc`<=`pc`; `pc`<=EXC_PC; `exc`<=1; `fetch_valid`<=0.
  - jump: `pc`<=jump target.
  - branch_taken: `pc`<=branch target.
  - else: `pc`<=`add_rst`.
- STALL: `pc` held. `jump`, `branch_taken` and `add_overflow` are ignored. When `stall`=0: -> RUN, `fetch_valid`<=1.
- TRAP: `exc`<=0; `pc` held at EXC_PC. If `stall`=1 -> STALL; else -> RUN with `fetch_valid`<=1.
- `epc` changes only on entry to TRAP. It holds its value otherwise, including through later stalls.
- `pc`[1:0] is always 2'b00 provided RESET_PC and EXC_PC are word-aligned.

## Timing
- Redirect latency is one cycle: control inputs sampled at edge N appear on `pc` after edge N.
- Control inputs are sampled only while in RUN.
- First valid fetch: the first rising edge after `rst_n` rises enters RUN. `fetch_valid`=1 with `pc`=RESET_PC.
- The `Add1` path is combinational within one cycle: `pc` -> `add_rst`/`add_overflow` -> next-PC mux -> `pc` register.
- Trap: `exc` is high for exactly one cycle, coincident with `pc`=EXC_PC and `fetch_valid`=0. The vector fetch becomes valid the following cycle.
- `stall` asserted in RUN: `fetch_valid` drops after the same edge. The fetch is valid again one cycle after `stall` is sampled low.
- Simultaneous `jump` and `branch_taken`: jump wins.
- Simultaneous `stall` and `add_overflow`: no trap is taken. Overflow is re-evaluated when RUN resumes.
- Reset asserted mid-operation (any state, including TRAP): immediate return to reset values, with no wait for a clock edge.

## Test plan
- Reset then 4 free-run cycles with `Add1` connected -> `pc` = 0, 0, 4, 8, 0xC. `fetch_valid`=0 during BOOT, then 1.
- At `pc`=0x10, `branch_taken`=1 with `branch_offset`=32'hFFFF_FFFE -> next `pc`=0x0C. At `pc`=0x0C, `jump`=1 and `branch_taken`=1 with `jump_target`=26'h40 -> `pc`=0x100.
- `stall` high for 3 cycles at `pc`=0x8 with `jump` pulsed during the stall -> `pc` stays 0x8 and `fetch_valid`=0 for 3 cycles. Then `pc`=0xC; the jump is ignored.
- RESET_PC=32'h7FFF_FFF8 -> `pc` 0x7FFF_FFF8, then 0x7FFF_FFFC. `add_overflow`=1 -> `exc` pulses, `epc`=0x7FFF_FFFC, `pc`=0x80. Next cycle `fetch_valid`=1, then `pc`=0x84.
- Overflow coincident with `stall` -> no `exc`. The trap is taken on the first RUN cycle after `stall` falls.
- `rst_n` pulsed low mid-cycle while in TRAP -> `pc`=RESET_PC, `exc`=0, `epc`=0 before the next edge. The BOOT sequence then repeats.
